// File: rtl/rvc_align_pkg.sv
// Shared types and helpers for the RV32IC instruction aligner.
// Holds the halfword buffer state encoding and the compressed-instruction test.
package rvc_align_pkg;

  typedef enum logic [1:0] {
    EMPTY      = 2'b00,
    HALF       = 2'b01,
    FULL       = 2'b10,
    EMPTY_SKIP = 2'b11
  } align_state_e;

  localparam logic [1:0] RVC_REGULAR = 2'b11;

  function automatic logic is_compressed(input logic [15:0] hw);
    return hw[1:0] != RVC_REGULAR;
  endfunction

endpackage

// File: rtl/rvc_instr_aligner.sv
// RV32IC fetch-word to instruction aligner: takes 32-bit word-aligned fetch
// words (fetch_valid/fetch_ready, fetch_data, fetch_pc) and emits one aligned
// 16- or 32-bit instruction per handshake (instr_valid/instr_ready,
// instr_data, instr_pc, instr_comp). flush/flush_half redirect the stream;
// aclk is the clock and areset an asynchronous active-high reset.
module rvc_instr_aligner
  import rvc_align_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic            flush,
  input  logic            flush_half,
  input  logic            fetch_valid,
  output logic            fetch_ready,
  input  logic [31:0]     fetch_data,
  input  logic [PC_W-1:0] fetch_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr_data,
  output logic [PC_W-1:0] instr_pc,
  output logic            instr_comp
);

  align_state_e    state_q, state_d;
  logic [31:0]     hbuf_q, hbuf_d;
  logic [PC_W-1:0] hpc_q, hpc_d;
  logic            ready_c;
  logic [15:0]     lo;
  logic            comp;

  assign lo   = hbuf_q[15:0];
  assign comp = is_compressed(lo);

  // No fetch word may be taken while reset is held.
  assign fetch_ready = ready_c & ~areset;

  always_comb begin
    state_d     = state_q;
    hbuf_d      = hbuf_q;
    hpc_d       = hpc_q;
    ready_c     = 1'b0;
    instr_valid = 1'b0;
    instr_data  = '0;
    instr_pc    = '0;
    instr_comp  = 1'b0;
    unique case (state_q)
      EMPTY: begin
        ready_c = 1'b1;
        if (fetch_valid) begin
          hbuf_d  = fetch_data;
          hpc_d   = fetch_pc;
          state_d = FULL;
        end
      end
      EMPTY_SKIP: begin
        ready_c = 1'b1;
        if (fetch_valid) begin
          hbuf_d[15:0] = fetch_data[31:16];
          hpc_d        = fetch_pc + PC_W'(2);
          state_d      = HALF;
        end
      end
      FULL: begin
        instr_valid = 1'b1;
        instr_pc    = hpc_q;
        instr_comp  = comp;
        instr_data  = comp ? {16'h0, lo} : hbuf_q;
        if (instr_ready) begin
          if (comp) begin
            hbuf_d[15:0] = hbuf_q[31:16];
            hpc_d        = hpc_q + PC_W'(2);
            state_d      = HALF;
          end else begin
            hpc_d   = hpc_q + PC_W'(4);
            state_d = EMPTY;
          end
        end
      end
      HALF: begin
        ready_c    = instr_ready;
        instr_pc   = hpc_q;
        instr_comp = comp;
        if (comp) begin
          instr_valid = 1'b1;
          instr_data  = {16'h0, lo};
          if (instr_ready) begin
            if (fetch_valid) begin
              hbuf_d  = fetch_data;
              hpc_d   = fetch_pc;
              state_d = FULL;
            end else begin
              hpc_d   = hpc_q + PC_W'(2);
              state_d = EMPTY;
            end
          end
        end else begin
          // Upper half of a straddling instruction comes straight from the
          // fetch port, so it is only valid while a word is offered.
          instr_valid = fetch_valid;
          instr_data  = {fetch_data[15:0], lo};
          if (instr_ready && fetch_valid) begin
            hbuf_d[15:0] = fetch_data[31:16];
            hpc_d        = fetch_pc + PC_W'(2);
          end
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      instr_valid = 1'b0;
      ready_c     = 1'b0;
      hbuf_d      = hbuf_q;
      hpc_d       = hpc_q;
      state_d     = flush_half ? EMPTY_SKIP : EMPTY;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= EMPTY;
      hbuf_q  <= '0;
      hpc_q   <= '0;
    end else begin
      state_q <= state_d;
      hbuf_q  <= hbuf_d;
      hpc_q   <= hpc_d;
    end
  end

endmodule

// File: tb/tb_rvc_instr_aligner.sv
// Self-checking bench for rvc_instr_aligner.
// Halfword-queue reference model; directed cases then random traffic.
module tb_rvc_instr_aligner;

  logic        aclk = 1'b0;
  logic        areset;
  logic        flush, flush_half;
  logic        fetch_valid, fetch_ready;
  logic [31:0] fetch_data, fetch_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr_data, instr_pc;
  logic        instr_comp;

  rvc_instr_aligner #(.PC_W(32)) dut (
    .aclk        (aclk),
    .areset      (areset),
    .flush       (flush),
    .flush_half  (flush_half),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_data  (fetch_data),
    .fetch_pc    (fetch_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_data  (instr_data),
    .instr_pc    (instr_pc),
    .instr_comp  (instr_comp)
  );

  always #5 aclk = ~aclk;

  int errs = 0;
  int checks = 0;

  logic [15:0] q_hw[$];
  logic [31:0] q_pc[$];
  logic        skip;
  logic        last_acc;
  int          fire_cnt;
  logic [31:0] last_d, last_p;
  logic [31:0] obs_d, obs_p;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic is_c(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

  task automatic model_clear(input logic sk);
    q_hw.delete();
    q_pc.delete();
    skip = sk;
  endtask

  // Sampled at negedge: expected handshakes, then queue update.
  task automatic model_step();
    logic ev, er, acc, fire, ec;
    logic [31:0] ed, ep;
    int n;
    n  = q_hw.size();
    ev = 1'b0;
    if (n >= 1) ev = (is_c(q_hw[0]) || n >= 2) ? 1'b1 : fetch_valid;
    er = (n == 0) || (n == 1 && instr_ready);
    if (flush) begin
      ev = 1'b0;
      er = 1'b0;
    end
    obs_d = instr_data;
    obs_p = instr_pc;
    check("instr_valid", 32'(instr_valid), 32'(ev));
    check("fetch_ready", 32'(fetch_ready), 32'(er));
    acc = fetch_valid && er;
    fire = ev && instr_ready;
    last_acc = acc;
    if (flush) begin
      model_clear(flush_half);
    end else begin
      if (acc) begin
        if (!skip) begin
          q_hw.push_back(fetch_data[15:0]);
          q_pc.push_back(fetch_pc);
        end
        q_hw.push_back(fetch_data[31:16]);
        q_pc.push_back(fetch_pc + 32'd2);
        skip = 1'b0;
      end
      if (fire) begin
        ec = is_c(q_hw[0]);
        ep = q_pc[0];
        ed = {16'h0, q_hw[0]};
        if (!ec && q_hw.size() >= 2) ed = {q_hw[1], q_hw[0]};
        void'(q_hw.pop_front());
        void'(q_pc.pop_front());
        if (!ec && q_hw.size() >= 1) begin
          void'(q_hw.pop_front());
          void'(q_pc.pop_front());
        end
        check("instr_data", instr_data, ed);
        check("instr_pc", instr_pc, ep);
        check("instr_comp", 32'(instr_comp), 32'(ec));
        fire_cnt++;
        last_d = instr_data;
        last_p = instr_pc;
      end
    end
  endtask

  task automatic tick(input logic fv, input logic [31:0] fd,
                      input logic [31:0] fp, input logic ir,
                      input logic fl, input logic fh);
    #1;
    fetch_valid = fv;
    fetch_data  = fd;
    fetch_pc    = fp;
    instr_ready = ir;
    flush       = fl;
    flush_half  = fh;
    @(negedge aclk);
    model_step();
    @(posedge aclk);
  endtask

  function automatic logic [15:0] rand_hw();
    logic [15:0] h;
    h = 16'($urandom);
    if ($urandom_range(1, 0) == 1) h[1:0] = 2'b11;
    return h;
  endfunction

  logic        pend_v;
  logic [31:0] pend_d, pend_p, next_pc;
  logic        r_fl;

  initial begin
    areset = 1'b1;
    flush = 0; flush_half = 0;
    fetch_valid = 0; fetch_data = 0; fetch_pc = 0;
    instr_ready = 0;
    fire_cnt = 0; last_d = 0; last_p = 0;
    model_clear(1'b0);
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_ready", 32'(fetch_ready), 32'd0);
    check("rst_data", instr_data, 32'd0);
    check("rst_pc", instr_pc, 32'd0);
    check("rst_comp", 32'(instr_comp), 32'd0);
    areset = 1'b0;
    @(posedge aclk);

    // two compressed
    tick(1, 32'h00010001, 32'h100, 1, 0, 0);
    tick(0, 0, 0, 1, 0, 0);
    check("c2_first_d", last_d, 32'h1);
    check("c2_first_p", last_p, 32'h100);
    tick(0, 0, 0, 1, 0, 0);
    check("c2_second_p", last_p, 32'h102);

    // aligned regular
    tick(1, 32'h00000013, 32'h200, 1, 0, 0);
    tick(0, 0, 0, 1, 0, 0);
    check("reg_d", last_d, 32'h13);
    check("reg_p", last_p, 32'h200);
    tick(0, 0, 0, 1, 0, 0);

    // straddle
    tick(1, 32'h00130001, 32'h300, 1, 0, 0);
    tick(0, 0, 0, 1, 0, 0);
    tick(1, 32'h00010000, 32'h304, 1, 0, 0);
    check("strad_d", last_d, 32'h13);
    check("strad_p", last_p, 32'h302);
    tick(0, 0, 0, 1, 0, 0);
    check("strad_tail_p", last_p, 32'h306);

    // backpressure in FULL
    tick(1, 32'h00000013, 32'h500, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(1, 32'h00000001, 32'h504, 0, 0, 0);
      check("bp_hold_d", obs_d, 32'h13);
      check("bp_hold_p", obs_p, 32'h500);
    end
    tick(1, 32'h00000001, 32'h504, 1, 0, 0);
    tick(1, 32'h00000001, 32'h504, 1, 0, 0);
    tick(0, 0, 0, 1, 0, 0);
    check("bp_next_p", last_p, 32'h504);
    tick(0, 0, 0, 1, 0, 0);

    // flush to upper halfword
    tick(1, 32'h00000013, 32'h400, 0, 0, 0);
    tick(0, 0, 0, 1, 1, 1);
    fire_cnt = 0;
    tick(1, 32'h0001ABCD, 32'h404, 1, 0, 0);
    tick(0, 0, 0, 1, 0, 0);
    tick(0, 0, 0, 1, 0, 0);
    check("flush_fires", 32'(fire_cnt), 32'd1);
    check("flush_d", last_d, 32'h1);
    check("flush_p", last_p, 32'h406);

    // async reset mid-straddle
    tick(1, 32'h00130001, 32'h600, 1, 0, 0);
    tick(0, 0, 0, 1, 0, 0);
    #1;
    fetch_valid = 1; fetch_data = 32'h00010000;
    fetch_pc = 32'h604; instr_ready = 1;
    #1 check("strad_pre_v", 32'(instr_valid), 32'd1);
    #1 areset = 1'b1;
    #1;
    check("arst_valid", 32'(instr_valid), 32'd0);
    check("arst_ready", 32'(fetch_ready), 32'd0);
    model_clear(1'b0);
    fetch_valid = 0;
    @(negedge aclk);
    @(negedge aclk);
    check("arst_pc", instr_pc, 32'd0);
    check("arst_data", instr_data, 32'd0);
    areset = 1'b0;
    @(posedge aclk);
    tick(1, 32'h00000013, 32'h700, 1, 0, 0);
    tick(0, 0, 0, 1, 0, 0);
    check("post_rst_p", last_p, 32'h700);

    // random traffic
    pend_v = 0; pend_d = 0; pend_p = 0;
    next_pc = 32'h1000;
    for (int i = 0; i < 4000; i++) begin
      if (!pend_v && $urandom_range(3, 0) != 0) begin
        pend_v = 1;
        pend_d = {rand_hw(), rand_hw()};
        pend_p = next_pc;
        next_pc = next_pc + 32'd4;
      end
      r_fl = ($urandom_range(19, 0) == 0);
      tick(pend_v, pend_d, pend_p, $urandom_range(3, 0) != 0,
           r_fl, 1'($urandom));
      if (last_acc && !r_fl) pend_v = 0;
      if (r_fl) begin
        pend_v = 0;
        next_pc = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF8
                                              : ($urandom & 32'hFFFF_FFFC);
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
